multiplier_4_bits_seq: RTL and testbench

Sequential 4-bit unsigned shift-and-add multiplier. It is the inverse datapath of the 4-bit restoring divider and is used to rebuild the dividend from quotient and divisor. It accepts one operand pair per start pulse, iterates one multiplier bit per clock, and returns an 8-bit product with a one-cycle done pulse. A compile-time option folds a 4-bit remainder into the result (q*b + r) so divider outputs can be checked end to end.

---
 rtl/multiplier_pkg.sv | 27 ++
 rtl/multiplier_4_bits_seq_mult_add_stage.sv | 22 ++
 rtl/multiplier_4_bits_seq.sv | 111 +++++++++++
 tb/tb_multiplier_4_bits_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_pkg
//  Description : Shared widths and state encoding for the sequential 4-bit
//                shift-and-add multiplier.
//                  OPND_W    - operand width (a, b, r)
//                  PROD_W    - product width
//                  STEP_W    - iteration counter width
//                  STEP_LAST - counter value of the final iteration
//  Revision    : 1.0 - initial release
// ============================================================================
package multiplier_pkg;

   localparam int OPND_W = 4;
   localparam int PROD_W = 8;
   localparam int STEP_W = 2;

   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(OPND_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

endpackage : multiplier_pkg
`default_nettype wire

// File: rtl/multiplier_4_bits_seq_mult_add_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mult_add_stage
//  Description : Unsigned OPND_W + OPND_W adder with carry out, producing the
//                partial sum for one shift-and-add iteration.
//  Ports       : i_addend_a [OPND_W-1:0] - accumulator high part
//                i_addend_b [OPND_W-1:0] - multiplicand
//                o_sum      [OPND_W:0]   - {carry, sum}
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_add_stage
   import multiplier_pkg::*;
(
   input  logic [OPND_W-1:0] i_addend_a,
   input  logic [OPND_W-1:0] i_addend_b,
   output logic [OPND_W:0]   o_sum
);

   assign o_sum = {1'b0, i_addend_a} + {1'b0, i_addend_b};

endmodule : mult_add_stage
`default_nettype wire

// File: rtl/multiplier_4_bits_seq.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_4_bits_seq
//  Description : Sequential 4-bit unsigned shift-and-add multiplier. One
//                operand pair per start, one multiplier bit per clock, 8-bit
//                product with a one-cycle done pulse.
//                Build option MULT_ADD_REMAINDER_EN adds port r and returns
//                a*b + r (used to rebuild a dividend from divider outputs).
//  Ports       : clk     - rising-edge clock
//                rst     - asynchronous active-high reset
//                start   - request, sampled only in IDLE
//                a       - multiplicand
//                b       - multiplier
//                r       - addend (MULT_ADD_REMAINDER_EN only)
//                busy    - high in RUN and DONE
//                done    - one-cycle pulse, product valid
//                product - result, held until the next completion
//  Revision    : 1.0 - initial release
// ============================================================================
module multiplier_4_bits_seq
   import multiplier_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
`ifdef MULT_ADD_REMAINDER_EN
   input  logic [OPND_W-1:0] r,
`endif
   output logic              busy,
   output logic              done,
   output logic [PROD_W-1:0] product
);

   mult_state_t        r_state;
   mult_state_t        w_next_state;
   logic [STEP_W-1:0]  r_step;
   logic [OPND_W-1:0]  r_mcand;
   // Accumulator: high nibble is the running partial product, low nibble the
   // not-yet-consumed multiplier bits. The ninth bit only exists as the adder
   // carry and is always zero after the shift, so it is not stored.
   logic [PROD_W-1:0]  r_acc;
   logic [PROD_W-1:0]  r_product;

   logic [OPND_W-1:0]  w_hi_seed;
   logic [OPND_W:0]    w_sum;
   logic [OPND_W:0]    w_hi_next;
   logic [PROD_W-1:0]  w_acc_shift;

`ifdef MULT_ADD_REMAINDER_EN
   // Seeding the high half with r adds r*2^4 before four right shifts,
   // which contributes exactly r to the final product.
   assign w_hi_seed = r;
`else
   assign w_hi_seed = '0;
`endif

   mult_add_stage u_add (
      .i_addend_a (r_acc[PROD_W-1:OPND_W]),
      .i_addend_b (r_mcand),
      .o_sum      (w_sum)
   );

   assign w_hi_next   = r_acc[0] ? w_sum : {1'b0, r_acc[PROD_W-1:OPND_W]};
   // Right shift of {carry, hi, lo}: bit 8 zero-fills, lsb of lo drops out.
   assign w_acc_shift = {w_hi_next, r_acc[OPND_W-1:1]};

   always_comb begin
      w_next_state = r_state;
      busy         = (r_state != IDLE);
      done         = (r_state == DONE);
      case (r_state)
         IDLE:    if (start) w_next_state = RUN;
         RUN:     if (r_step == STEP_LAST) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_step    <= '0;
         r_mcand   <= '0;
         r_acc     <= '0;
         r_product <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand <= a;
                  r_acc   <= {w_hi_seed, b};
                  r_step  <= '0;
               end
            end
            RUN: begin
               r_acc  <= w_acc_shift;
               r_step <= r_step + 1'b1;
               if (r_step == STEP_LAST) r_product <= w_acc_shift;
            end
            default: ;
         endcase
      end
   end

   assign product = r_product;

endmodule : multiplier_4_bits_seq
`default_nettype wire

// File: tb/tb_multiplier_4_bits_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiplier_4_bits_seq
//  Description : Self-checking bench for multiplier_4_bits_seq. Expected
//                products are queued when a request is driven and compared
//                when done pulses. Build with MULT_ADD_REMAINDER_EN to cover
//                the remainder-add option and divider loopback.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_4_bits_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] ai = '0;
   logic [3:0] bi = '0;
   logic [3:0] ri = '0;
   logic       busy;
   logic       done;
   logic [7:0] product;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   logic [7:0] sb_q[$];
   int         done_cyc[$];

   multiplier_4_bits_seq dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (ai),
      .b       (bi),
`ifdef MULT_ADD_REMAINDER_EN
      .r       (ri),
`endif
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard consumer: every done must match the oldest outstanding request.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cyc.push_back(cyc);
         if (sb_q.size() == 0) check("spurious_done", 16'd1, 16'd0);
         else                  check("product", {8'h00, product}, {8'h00, sb_q.pop_front()});
      end
   end

   // One request from IDLE with full latency checks around it.
   task automatic run_one(input logic [3:0] a_v, input logic [3:0] b_v,
                          input logic [3:0] r_v, input logic [7:0] exp);
      @(negedge clk);
      ai = a_v; bi = b_v; ri = r_v; start = 1'b1;
      sb_q.push_back(exp);
      @(negedge clk);                      // E0 has passed
      start = 1'b0;
      check("busy_after_e0", {15'd0, busy}, 16'd1);
      ai = ~a_v; bi = ~b_v; ri = ~r_v;     // late operand changes must not matter
      repeat (3) begin
         @(negedge clk);
         check("done_early", {15'd0, done}, 16'd0);
      end
      @(negedge clk);                      // after E4
      check("done_after_e4", {15'd0, done}, 16'd1);
      @(negedge clk);                      // after E5
      check("done_after_e5", {15'd0, done}, 16'd0);
      check("busy_after_e5", {15'd0, busy}, 16'd0);
   endtask

   initial begin
      logic [3:0] ra, rb;
      #3;
      check("rst_busy",    {15'd0, busy}, 16'd0);
      check("rst_done",    {15'd0, done}, 16'd0);
      check("rst_product", {8'd0, product}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_one(4'd7,  4'd3, 4'd0, 8'd21);
      run_one(4'd15, 4'd15, 4'd0, 8'hE1);
      run_one(4'd0,  4'd9, 4'd0, 8'h00);

      // Start pulses while busy are ignored; start held high gets 6-cycle spacing.
      done_cyc.delete();
      @(negedge clk);
      ai = 4'd7; bi = 4'd3; ri = 4'd0; start = 1'b1;
      sb_q.push_back(8'd21);
      @(negedge clk); start = 1'b0;                          // after E0
      @(negedge clk); ai = 4'd1; bi = 4'd1; start = 1'b1;    // sampled at E2
      @(negedge clk); start = 1'b0;
      @(negedge clk); ai = 4'd2; bi = 4'd5; start = 1'b1;    // held from here
      sb_q.push_back(8'd10);
      repeat (4) @(negedge clk);                             // after E7
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("held_done_count", 16'(done_cyc.size()), 16'd2);
      if (done_cyc.size() == 2)
         check("done_spacing", 16'(done_cyc[1] - done_cyc[0]), 16'd6);

      // Asynchronous reset between E2 and E3 aborts without a done.
      @(negedge clk);
      ai = 4'd9; bi = 4'd9; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(posedge clk); @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy",    {15'd0, busy}, 16'd0);
      check("abort_done",    {15'd0, done}, 16'd0);
      check("abort_product", {8'd0, product}, 16'd0);
      @(negedge clk); rst = 1'b0;
      repeat (8) @(negedge clk);
      run_one(4'd5, 4'd5, 4'd0, 8'd25);

`ifdef MULT_ADD_REMAINDER_EN
      run_one(4'd3,  4'd5,  4'd2,  8'd17);
      run_one(4'd15, 4'd15, 4'd15, 8'd240);
      // Divider loopback: q*b + rem must rebuild the dividend.
      for (int k = 0; k < 16; k++) begin
         rb = 4'($urandom_range(1, 15));
         run_one(4'(k / int'(rb)), rb, 4'(k % int'(rb)), 8'(k));
      end
`else
      for (int k = 0; k < 12; k++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         run_one(ra, rb, 4'd0, 8'(int'(ra) * int'(rb)));
      end
`endif

      repeat (4) @(negedge clk);
      check("scoreboard_empty", 16'(sb_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_multiplier_4_bits_seq
`default_nettype wire
